image_pipe_dma_scheduler: RTL

Sequences the two MM2S DMA channels that feed the image pipe's two input streams. Once per configured job, it issues read commands for one full image per iteration, repeated for every output-channel iteration, because the image pipe reloads its header on every image. Commands are split into bounded chunks, with EOF on the last chunk so the stream's TLAST lands at image end. Channel 2 is used only in maxpool mode. The block collects per-chunk DMA status, and reports completion and errors.

---
 rtl/image_pipe_dma_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/image_pipe_dma_scheduler.sv
// rtl/image_pipe_dma_scheduler.sv - MM2S command sequencer and status collector for the image pipe inputs
// Issues one full image per iteration on each active channel, split into EOF-terminated chunks.

module image_pipe_dma_scheduler #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTT_WIDTH   = 23,
    parameter int CHUNK_BYTES = 65536,
    parameter int BYTES_WIDTH = 32,
    parameter int ITERS_WIDTH = 16,
    parameter int TAG_WIDTH   = 4,
    parameter int CMD_WIDTH   = TAG_WIDTH + ADDR_WIDTH + 1 + BTT_WIDTH
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr_1,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr_2,
    input  logic [BYTES_WIDTH-1:0] cfg_bytes,
    input  logic [ITERS_WIDTH-1:0] cfg_iters,
    input  logic                   cfg_is_max,
    output logic                   m_cmd_1_tvalid,
    input  logic                   m_cmd_1_tready,
    output logic [CMD_WIDTH-1:0]   m_cmd_1_tdata,
    output logic                   m_cmd_2_tvalid,
    input  logic                   m_cmd_2_tready,
    output logic [CMD_WIDTH-1:0]   m_cmd_2_tdata,
    input  logic                   s_sts_1_tvalid,
    output logic                   s_sts_1_tready,
    input  logic [7:0]             s_sts_1_tdata,
    input  logic                   s_sts_2_tvalid,
    output logic                   s_sts_2_tready,
    input  logic [7:0]             s_sts_2_tdata,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int SHIFT = $clog2(CHUNK_BYTES);
    localparam logic [BYTES_WIDTH-1:0] CHUNK_B = BYTES_WIDTH'(CHUNK_BYTES);
    localparam logic [ADDR_WIDTH-1:0]  CHUNK_A = ADDR_WIDTH'(CHUNK_BYTES);
    localparam logic [BTT_WIDTH-1:0]   CHUNK_T = BTT_WIDTH'(CHUNK_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]  base_1, base_2, addr_1, addr_2;
    logic [BYTES_WIDTH-1:0] bytes_q, rem_1, rem_2, sc_1, sc_2, n_chunks;
    logic [ITERS_WIDTH-1:0] iters_q, iter;
    logic                   is_max_q, err;
    logic [BTT_WIDTH-1:0]   btt_1, btt_2;
    logic                   cfg_fire, zero_job, issued_1, issued_2;
    logic                   take_1, take_2, ok_1, ok_2, iter_end, last_iter;
    logic                   unused_sts;

    assign unused_sts = ^{s_sts_1_tdata[3:0], s_sts_2_tdata[3:0]};

    assign n_chunks  = (bytes_q >> SHIFT) + BYTES_WIDTH'(|bytes_q[SHIFT-1:0]);
    assign cfg_fire  = cfg_valid && (state == IDLE);
    assign zero_job  = (cfg_bytes == '0) || (cfg_iters == '0);
    assign btt_1     = (rem_1 >= CHUNK_B) ? CHUNK_T : rem_1[BTT_WIDTH-1:0];
    assign btt_2     = (rem_2 >= CHUNK_B) ? CHUNK_T : rem_2[BTT_WIDTH-1:0];

    // A channel has finished issuing once nothing remains and its last word is accepted.
    assign issued_1  = (rem_1 == '0) && (!m_cmd_1_tvalid || m_cmd_1_tready);
    assign issued_2  = (rem_2 == '0) && (!m_cmd_2_tvalid || m_cmd_2_tready);

    assign ok_1      = s_sts_1_tdata[7] && (s_sts_1_tdata[6:4] == 3'b000);
    assign ok_2      = s_sts_2_tdata[7] && (s_sts_2_tdata[6:4] == 3'b000);
    assign take_1    = s_sts_1_tvalid && (state == ISSUE || state == WAIT) && (sc_1 != n_chunks);
    assign take_2    = s_sts_2_tvalid && is_max_q && (state == ISSUE || state == WAIT)
                       && (sc_2 != n_chunks);
    assign iter_end  = (state == WAIT) && (sc_1 == n_chunks) && (!is_max_q || sc_2 == n_chunks);
    assign last_iter = err || ((iter + ITERS_WIDTH'(1)) == iters_q);

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        cfg_ready      = (state == IDLE);
        busy           = (state != IDLE);
        done           = (state == DONE);
        error          = err;
        s_sts_1_tready = 1'b1;
        s_sts_2_tready = 1'b1;
        case (state)
            IDLE:    if (cfg_fire) state_nxt = zero_job ? DONE : ISSUE;
            ISSUE:   if (issued_1 && issued_2) state_nxt = WAIT;
            WAIT:    if (iter_end) state_nxt = last_iter ? DONE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            base_1 <= '0; base_2 <= '0; addr_1 <= '0; addr_2 <= '0;
            bytes_q <= '0; rem_1 <= '0; rem_2 <= '0; sc_1 <= '0; sc_2 <= '0;
            iters_q <= '0; iter <= '0; is_max_q <= 1'b0; err <= 1'b0;
            m_cmd_1_tvalid <= 1'b0; m_cmd_1_tdata <= '0;
            m_cmd_2_tvalid <= 1'b0; m_cmd_2_tdata <= '0;
        end else begin
            if (state != ISSUE) begin
                m_cmd_1_tvalid <= 1'b0;
                m_cmd_2_tvalid <= 1'b0;
            end else begin
                if (!m_cmd_1_tvalid || m_cmd_1_tready) begin
                    m_cmd_1_tvalid <= (rem_1 != '0);
                    if (rem_1 != '0) begin
                        m_cmd_1_tdata <= {iter[TAG_WIDTH-1:0], addr_1, (rem_1 <= CHUNK_B), btt_1};
                        addr_1        <= addr_1 + CHUNK_A;
                        rem_1         <= (rem_1 >= CHUNK_B) ? rem_1 - CHUNK_B : '0;
                    end
                end
                if (!m_cmd_2_tvalid || m_cmd_2_tready) begin
                    m_cmd_2_tvalid <= (rem_2 != '0);
                    if (rem_2 != '0) begin
                        m_cmd_2_tdata <= {iter[TAG_WIDTH-1:0], addr_2, (rem_2 <= CHUNK_B), btt_2};
                        addr_2        <= addr_2 + CHUNK_A;
                        rem_2         <= (rem_2 >= CHUNK_B) ? rem_2 - CHUNK_B : '0;
                    end
                end
            end

            if (take_1) begin
                sc_1 <= sc_1 + BYTES_WIDTH'(1);
                if (!ok_1) err <= 1'b1;
            end
            if (take_2) begin
                sc_2 <= sc_2 + BYTES_WIDTH'(1);
                if (!ok_2) err <= 1'b1;
            end

            // Both job start and iteration restart rewind the channels to the image base.
            if (cfg_fire) begin
                base_1 <= cfg_addr_1; base_2 <= cfg_addr_2;
                bytes_q <= cfg_bytes; iters_q <= cfg_iters; is_max_q <= cfg_is_max;
                err <= 1'b0; iter <= '0; sc_1 <= '0; sc_2 <= '0;
                addr_1 <= cfg_addr_1; addr_2 <= cfg_addr_2;
                rem_1 <= cfg_bytes;
                rem_2 <= cfg_is_max ? cfg_bytes : '0;
            end else if (iter_end && !last_iter) begin
                iter <= iter + ITERS_WIDTH'(1);
                sc_1 <= '0; sc_2 <= '0;
                addr_1 <= base_1; addr_2 <= base_2;
                rem_1 <= bytes_q;
                rem_2 <= is_max_q ? bytes_q : '0;
            end
        end
    end

endmodule
